// File: rtl/channelizer_pkg.sv
// Shared control-word definition for the time-multiplexed channelizer stream.
package channelizer_pkg;

    localparam int CHANNELIZER_INDEX_WIDTH = 4;

    typedef struct packed {
        logic                               valid;
        logic                               last;
        logic [CHANNELIZER_INDEX_WIDTH-1:0] data_index;
    } channelizer_control_t;

endpackage

// File: rtl/channelized_dds_gain.sv
// Per-channel complex gain stage for the channelized DDS stream.
// Each sample is multiplied by a programmable per-channel signed gain,
// rounded half-up, saturated and forwarded with its control word three
// cycles later. Clipped output samples are counted for status readback.
module channelized_dds_gain
    import channelizer_pkg::*;
#(
    parameter int NUM_CHANNELS        = 16,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int INPUT_DATA_WIDTH    = 12,
    parameter int OUTPUT_DATA_WIDTH   = 12,
    parameter int GAIN_WIDTH          = 16,
    parameter int GAIN_FRAC_BITS      = 14
) (
    input  logic                                  Clk,
    input  logic                                  Rst,
    input  logic                                  Gain_wr_valid,
    input  logic [CHANNEL_INDEX_WIDTH-1:0]        Gain_wr_index,
    input  logic [GAIN_WIDTH-1:0]                 Gain_wr_data,
    input  channelizer_control_t                  Input_ctrl,
    input  logic [1:0][INPUT_DATA_WIDTH-1:0]      Input_data,
    output channelizer_control_t                  Output_ctrl,
    output logic [1:0][OUTPUT_DATA_WIDTH-1:0]     Output_data,
    output logic [31:0]                           Sat_count
);

    localparam int ProdW = INPUT_DATA_WIDTH + GAIN_WIDTH;

    localparam logic signed [GAIN_WIDTH-1:0] UnityGain = GAIN_WIDTH'(1) <<< GAIN_FRAC_BITS;
    localparam logic signed [ProdW-1:0]      HalfLsb   = ProdW'(1) <<< (GAIN_FRAC_BITS - 1);
    localparam logic signed [ProdW-1:0]      OutMax    = (ProdW'(1) <<< (OUTPUT_DATA_WIDTH - 1)) - ProdW'(1);
    localparam logic signed [ProdW-1:0]      OutMin    = -(ProdW'(1) <<< (OUTPUT_DATA_WIDTH - 1));

    logic [GAIN_WIDTH-1:0]              gainRam [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]            configured_q;
    logic signed [GAIN_WIDTH-1:0]       effGain_d;

    channelizer_control_t               ctrl1_q, ctrl2_q, ctrl3_q;
    logic signed [INPUT_DATA_WIDTH-1:0] x1_q [2];
    logic signed [GAIN_WIDTH-1:0]       g1_q;
    logic signed [ProdW-1:0]            p2_q [2];
    logic signed [ProdW-1:0]            rounded_d [2];
    logic [1:0][OUTPUT_DATA_WIDTH-1:0]  outData_d, outData_q;
    logic [1:0]                         clip_d;
    logic [31:0]                        satCount_q;

    // Gain storage is plain RAM with no reset; a channel's contents only matter once it is configured.
    always_ff @(posedge Clk) begin
        if (Gain_wr_valid) begin
            gainRam[Gain_wr_index] <= Gain_wr_data;
        end
    end

    // Track which channels have ever been written so unwritten ones run at unity.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            configured_q <= '0;
        end else if (Gain_wr_valid) begin
            configured_q[Gain_wr_index] <= 1'b1;
        end
    end

    // Effective gain is read before this edge's write lands, so a colliding sample sees the old gain.
    always_comb begin
        effGain_d = UnityGain;
        if (configured_q[Input_ctrl.data_index]) begin
            effGain_d = $signed(gainRam[Input_ctrl.data_index]);
        end
    end

    // S1: capture the incoming sample together with the gain for its channel.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctrl1_q <= '0;
            g1_q    <= '0;
            for (int k = 0; k < 2; k++) x1_q[k] <= '0;
        end else begin
            ctrl1_q <= Input_ctrl;
            if (Input_ctrl.valid) begin
                g1_q <= effGain_d;
                for (int k = 0; k < 2; k++) x1_q[k] <= $signed(Input_data[k]);
            end
        end
    end

    // S2: full-precision signed products for I and Q.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctrl2_q <= '0;
            for (int k = 0; k < 2; k++) p2_q[k] <= '0;
        end else begin
            ctrl2_q <= ctrl1_q;
            if (ctrl1_q.valid) begin
                for (int k = 0; k < 2; k++) p2_q[k] <= ProdW'(x1_q[k]) * ProdW'(g1_q);
            end
        end
    end

    // S3 datapath: round half-up, then clamp; a rounding carry past full scale is clipped too.
    always_comb begin
        clip_d    = '0;
        outData_d = '0;
        for (int k = 0; k < 2; k++) begin
            rounded_d[k] = (p2_q[k] + HalfLsb) >>> GAIN_FRAC_BITS;
            if (rounded_d[k] > OutMax) begin
                outData_d[k] = OutMax[OUTPUT_DATA_WIDTH-1:0];
                clip_d[k]    = 1'b1;
            end else if (rounded_d[k] < OutMin) begin
                outData_d[k] = OutMin[OUTPUT_DATA_WIDTH-1:0];
                clip_d[k]    = 1'b1;
            end else begin
                outData_d[k] = rounded_d[k][OUTPUT_DATA_WIDTH-1:0];
            end
        end
    end

    // S3 registers: output data only moves on valid samples; the clip counter sticks at all-ones.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctrl3_q    <= '0;
            outData_q  <= '0;
            satCount_q <= '0;
        end else begin
            ctrl3_q <= ctrl2_q;
            if (ctrl2_q.valid) begin
                outData_q <= outData_d;
                if ((|clip_d) && (satCount_q != 32'hFFFF_FFFF)) begin
                    satCount_q <= satCount_q + 32'd1;
                end
            end
        end
    end

    assign Output_ctrl = ctrl3_q;
    assign Output_data = outData_q;
    assign Sat_count   = satCount_q;

endmodule

// File: doc/channelized_dds_gain.md
Name: channelized_dds_gain

Overview:
- Per-channel complex gain stage placed directly downstream of channelized_dds.
- Consumes the time-multiplexed DDS output stream (channelizer_control_t plus signed I/Q) and scales each sample by a programmable per-channel signed gain, with rounding and saturation.
- Forwards the scaled stream, with control fields unchanged, to the synthesizer output mux.
- Counts saturation events for status readback.

Parameters:
NUM_CHANNELS, 16, number of time-multiplexed channels
CHANNEL_INDEX_WIDTH, $clog2(NUM_CHANNELS), width of channel index / data_index
INPUT_DATA_WIDTH, 12, signed I/Q input width
OUTPUT_DATA_WIDTH, 12, signed I/Q output width
GAIN_WIDTH, 16, signed gain word width
GAIN_FRAC_BITS, 14, fractional bits of gain (0x4000 = unity)

Ports:
Clk  input  1  clock
Rst  input  1  reset, asynchronous, active-high
Gain_wr_valid  input  1  gain write strobe
Gain_wr_index  input  CHANNEL_INDEX_WIDTH  channel to write
Gain_wr_data  input  GAIN_WIDTH  signed gain, Q(GAIN_WIDTH-GAIN_FRAC_BITS).GAIN_FRAC_BITS
Input_ctrl  input  channelizer_control_t  valid/last/data_index from channelized_dds
Input_data  input  [1:0] x INPUT_DATA_WIDTH signed  [0]=I, [1]=Q
Output_ctrl  output  channelizer_control_t  delayed copy of Input_ctrl
Output_data  output  [1:0] x OUTPUT_DATA_WIDTH signed  scaled I/Q
Sat_count  output  32  number of output samples with I or Q saturated

Behaviour:
- Clk/Rst: one clock. Rst is asynchronous and active-high.
- Reset values:
  - Output_ctrl.valid=0; Output_ctrl.last/data_index=0; Output_data=0; Sat_count=0.
  - All pipeline valid bits are 0.
  - Per-channel "configured" bit vector [NUM_CHANNELS-1:0] is 0.
  - The gain RAM itself is not reset.
- Gain write:
  - When Gain_wr_valid is high on a clock edge, gain_ram[Gain_wr_index] <= Gain_wr_data and configured[Gain_wr_index] <= 1.
  - Writes are accepted on any cycle, independent of the data stream.
- Effective gain: configured[idx] ? gain_ram[idx] : unity (1<<GAIN_FRAC_BITS).
- Pipeline, fixed latency 3 cycles, no backpressure, one sample per cycle max:
  - S1: register Input_ctrl and Input_data; register a read of effective gain for Input_ctrl.data_index.
  - S2: full-precision signed products p = x*g, width INPUT_DATA_WIDTH+GAIN_WIDTH, for I and Q.
  - S3: round half-up, r = (p + 2^(GAIN_FRAC_BITS-1)) >>> GAIN_FRAC_BITS (arithmetic shift). Then saturate to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1]. Register into Output_data.
- Output_ctrl timing: Output_ctrl equals Input_ctrl from exactly 3 cycles earlier. last and data_index pass through unmodified.
- Output_data when invalid: on cycles where Output_ctrl.valid=0, Output_data holds its previous value. Consumers must ignore it.
- Invalid input cycles: no computation side effects. Sat_count is unchanged.
- Sat_count:
  - Increments by 1 on each output-valid cycle where I or Q (or both) was clipped.
  - Holds at 0xFFFFFFFF; does not wrap.
- Write/read collision: if a write to channel k and an S1 read of channel k occur on the same edge, that sample uses the OLD effective gain. Samples entering on the next cycle use the new gain.
- Rounding boundary: rounding overflow (e.g. r exceeds max after adding the half-LSB) is caught by saturation and counts as a saturation event.
- Reset mid-stream:
  - In-flight samples are discarded; no output valid is produced for them after Rst deasserts.
  - configured is cleared, so all channels revert to unity.
  - The first valid output appears 3 cycles after the first valid input following reset.
- Width rule: an unconfigured channel at unity with INPUT_DATA_WIDTH = OUTPUT_DATA_WIDTH is bit-exact pass-through, never saturates.

Test Plan:
- Unity pass-through, no writes after reset:
  - Stimulus: ch3 input I=1000, Q=-1000, valid, last=0.
  - Response: exactly 3 cycles later, valid=1, data_index=3, I=1000, Q=-1000; Sat_count=0.
- Half gain with rounding:
  - Stimulus: write ch5 gain 0x2000; then ch5 I=3, Q=-3.
  - Response: I=2, Q=-1 (half-up on ±1.5). Also ch5 I=-2048 gives I=-1024.
- Saturation:
  - Stimulus: ch0 gain 0x7FFF, input I=2047, Q=-2048.
  - Response: I=2047, Q=-2048, Sat_count=1.
  - Stimulus: ch0 gain 0x8000 (-2.0), I=-2048, Q=0.
  - Response: I=2047, Q=0, Sat_count=2.
- Collision:
  - Stimulus: write ch7 gain 0x2000 on the same edge a ch7 sample I=100 enters S1; ch7 I=100 again next cycle.
  - Response: outputs I=100, then I=50.
- Reset mid-stream:
  - Stimulus: full 16-channel back-to-back stream with all gains 0x2000; assert Rst for 2 cycles mid-frame; resume.
  - Response: no valid outputs for pre-reset samples; post-reset outputs equal inputs (unity); Sat_count=0.
- Randomised stream at 50% valid density, random gains and writes, checked against a reference model over 10,000 samples.
  - Response: zero mismatches; last/data_index preserved; Sat_count equals the model count.
